tlk2711_rx_dma_wr: RTL and testbench

- Downstream stage of the TLK2711 RX link.
- Accepts a write command (start address, byte length) plus a 64-bit FWFT-style data stream, and writes the data to DDR as AXI4 INCR write bursts.
- Returns the command ack, the data-ready and the write-finish pulse to the RX link.
- Sits between the RX link and the PS DDR AXI HP port.

---
 rtl/tlk2711_pkg.sv | 23 ++
 rtl/tlk2711_rx_dma_wr_if.sv | 39 +++
 rtl/tlk2711_burst_calc.sv | 19 +
 rtl/tlk2711_rx_dma_wr.sv | 176 +++++++++++++++++
 tb/tb_tlk2711_rx_dma_wr.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tlk2711_pkg.sv
// Shared definitions for the TLK2711 RX DMA write path: FSM encoding,
// AXI4 constants and a small helper used by the burst sizing logic.
package tlk2711_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CALC = 3'd1,
        ST_AW   = 3'd2,
        ST_W    = 3'd3,
        ST_B    = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_8B    = 3'd3;
    localparam logic [1:0] RESP_OKAY      = 2'b00;
    localparam int         BOUNDARY_4K    = 4096;

    function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/tlk2711_rx_dma_wr_if.sv
// AXI4 write-channel bundle (AW, W, B) between the DMA writer and the DDR port.
interface tlk2711_rx_dma_wr_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 64,
    parameter int WBYTE_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0]  awaddr;
    logic [7:0]             awlen;
    logic [2:0]             awsize;
    logic [1:0]             awburst;
    logic                   awvalid;
    logic                   awready;
    logic [DATA_WIDTH-1:0]  wdata;
    logic [WBYTE_WIDTH-1:0] wstrb;
    logic                   wlast;
    logic                   wvalid;
    logic                   wready;
    logic [1:0]             bresp;
    logic                   bvalid;
    logic                   bready;

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/tlk2711_burst_calc.sv
// Burst sizing: min(BURST_LEN, beats still to send, beats left before the
// next 4 KB boundary). The address is 8-byte aligned by the time it gets here.
module tlk2711_burst_calc
    import tlk2711_pkg::*;
#(
    parameter int BEATS_W   = 14,
    parameter int BURST_LEN = 16
) (
    input  logic [BEATS_W-1:0] beats_left,
    input  logic [11:0]        addr_lo,
    output logic [8:0]         burst
);
    logic [9:0] beats_to_4k;

    // Range 1..512: an aligned address always has at least one beat before the boundary.
    assign beats_to_4k = 10'((13'(BOUNDARY_4K) - {1'b0, addr_lo}) >> 3);

    assign burst = 9'(min_u(min_u(32'(BURST_LEN), 32'(beats_left)), 32'(beats_to_4k)));
endmodule

// File: rtl/tlk2711_rx_dma_wr.sv
// TLK2711 RX DMA writer: takes {address, byte length} commands plus a 64-bit
// FWFT beat stream and writes it to DDR as serialised AXI4 INCR bursts.
module tlk2711_rx_dma_wr
    import tlk2711_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DLEN_WIDTH  = 16,
    parameter int DATA_WIDTH  = 64,
    parameter int WBYTE_WIDTH = 8,
    parameter int BURST_LEN   = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_soft_rst,
    input  logic                             i_wr_cmd_req,
    input  logic [ADDR_WIDTH+DLEN_WIDTH-1:0] i_wr_cmd_data,
    output logic                             o_wr_cmd_ack,
    input  logic                             i_dma_wr_valid,
    input  logic [WBYTE_WIDTH-1:0]           i_dma_wr_keep,
    input  logic [DATA_WIDTH-1:0]            i_dma_wr_data,
    output logic                             o_dma_wr_ready,
    output logic                             o_wr_finish,
    tlk2711_rx_dma_wr_if.master              m_axi,
    output logic                             o_wr_err,
    output logic                             o_busy,
    output logic [2:0]                       o_state
);
    localparam int BEATS_W = DLEN_WIDTH - 2;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [BEATS_W-1:0]    beats_left;
        logic [8:0]            burst;
        logic [8:0]            w_left;
        logic                  err;
        logic                  ack;
        logic                  finish;
    } ctl_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]  data;
        logic [WBYTE_WIDTH-1:0] strb;
        logic                   valid;
        logic                   last;
    } wbeat_t;

    state_t                state, state_nxt;
    ctl_t                  ctl;
    wbeat_t                wq;
    logic [8:0]            burst_nxt;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DLEN_WIDTH-1:0] cmd_len;
    logic [BEATS_W-1:0]    cmd_beats;
    logic [BEATS_W-1:0]    beats_after;
    logic                  beat_acc;
    logic                  w_fire;

    assign cmd_addr    = i_wr_cmd_data[ADDR_WIDTH+DLEN_WIDTH-1:DLEN_WIDTH];
    assign cmd_len     = i_wr_cmd_data[DLEN_WIDTH-1:0];
    // A partial last word still occupies a full beat.
    assign cmd_beats   = BEATS_W'(cmd_len[DLEN_WIDTH-1:3]) + BEATS_W'(|cmd_len[2:0]);
    assign beats_after = ctl.beats_left - BEATS_W'(ctl.burst);

    assign w_fire         = wq.valid & m_axi.wready;
    // Ready depends only on output-register space and beats owed, never on valid.
    assign o_dma_wr_ready = (state == ST_W) & (~wq.valid | m_axi.wready) & (ctl.w_left != '0);
    assign beat_acc       = o_dma_wr_ready & i_dma_wr_valid;

    tlk2711_burst_calc #(
        .BEATS_W   (BEATS_W),
        .BURST_LEN (BURST_LEN)
    ) u_burst_calc (
        .beats_left (ctl.beats_left),
        .addr_lo    (ctl.addr[11:0]),
        .burst      (burst_nxt)
    );

    // State register; both reset flavours abandon any transfer in flight.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state <= ST_IDLE;
        end else if (i_soft_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: one burst at a time, AW -> W -> B, then resize or finish.
    always_comb begin
        // NOTE: default first so no path leaves state_nxt unassigned and infers a latch.
        state_nxt = state;
        case (state)
            ST_IDLE: if (i_wr_cmd_req) state_nxt = ST_CALC;
            ST_CALC: state_nxt = (ctl.beats_left == '0) ? ST_DONE : ST_AW;
            ST_AW:   if (m_axi.awready) state_nxt = ST_W;
            ST_W:    if (w_fire && wq.last) state_nxt = ST_B;
            ST_B:    if (m_axi.bvalid) state_nxt = (beats_after != '0) ? ST_CALC : ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Command context, per-burst bookkeeping, sticky error and one-cycle pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctl <= '0;
        end else if (i_soft_rst) begin
            ctl <= '0;
        end else begin
            ctl.ack    <= 1'b0;
            ctl.finish <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_wr_cmd_req) begin
                        ctl.ack        <= 1'b1;
                        ctl.addr       <= {cmd_addr[ADDR_WIDTH-1:3], 3'b000};
                        ctl.beats_left <= cmd_beats;
                        if (|cmd_addr[2:0]) ctl.err <= 1'b1;
                    end
                end
                ST_CALC: begin
                    ctl.burst  <= burst_nxt;
                    ctl.w_left <= burst_nxt;
                end
                ST_W: begin
                    if (beat_acc) ctl.w_left <= ctl.w_left - 9'd1;
                end
                ST_B: begin
                    if (m_axi.bvalid) begin
                        if (m_axi.bresp != RESP_OKAY) ctl.err <= 1'b1;
                        ctl.addr       <= ctl.addr + ADDR_WIDTH'({ctl.burst, 3'b000});
                        ctl.beats_left <= beats_after;
                    end
                end
                ST_DONE: ctl.finish <= 1'b1;
                default: ;
            endcase
        end
    end

    // W output register: one-cycle latency from accepted input beat to wvalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wq <= '0;
        end else if (i_soft_rst) begin
            wq <= '0;
        end else if (beat_acc) begin
            wq.data  <= i_dma_wr_data;
            wq.strb  <= i_dma_wr_keep;
            wq.valid <= 1'b1;
            wq.last  <= (ctl.w_left == 9'd1);
        end else if (w_fire) begin
            wq.valid <= 1'b0;
            wq.last  <= 1'b0;
        end
    end

    assign m_axi.awaddr  = ctl.addr;
    assign m_axi.awlen   = 8'(ctl.burst - 9'd1);
    assign m_axi.awsize  = AXI_SIZE_8B;
    assign m_axi.awburst = AXI_BURST_INCR;
    assign m_axi.awvalid = (state == ST_AW);
    assign m_axi.wdata   = wq.data;
    assign m_axi.wstrb   = wq.strb;
    assign m_axi.wlast   = wq.last;
    assign m_axi.wvalid  = wq.valid;
    assign m_axi.bready  = (state == ST_B);

    assign o_wr_cmd_ack = ctl.ack;
    assign o_wr_finish  = ctl.finish;
    assign o_wr_err     = ctl.err;
    assign o_busy       = (state != ST_IDLE);
    assign o_state      = state;
endmodule

// File: tb/tb_tlk2711_rx_dma_wr.sv
// Directed bench for tlk2711_rx_dma_wr: a table of commands with hand-computed
// burst layouts, plus hand-written error, zero-length and reset sequences.
module tb_tlk2711_rx_dma_wr;
    import tlk2711_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        soft_rst;
    logic        cmd_req;
    logic [47:0] cmd_data;
    logic        cmd_ack;
    logic        src_avail;
    logic        dma_valid;
    logic [7:0]  dma_keep;
    logic [63:0] dma_data;
    logic        dma_ready;
    logic        finish;
    logic        wr_err;
    logic        busy;
    logic [2:0]  state;

    always #5 clk = ~clk;

    tlk2711_rx_dma_wr_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .WBYTE_WIDTH(8)) axi ();

    tlk2711_rx_dma_wr #(
        .ADDR_WIDTH(32), .DLEN_WIDTH(16), .DATA_WIDTH(64), .WBYTE_WIDTH(8), .BURST_LEN(16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_soft_rst     (soft_rst),
        .i_wr_cmd_req   (cmd_req),
        .i_wr_cmd_data  (cmd_data),
        .o_wr_cmd_ack   (cmd_ack),
        .i_dma_wr_valid (dma_valid),
        .i_dma_wr_keep  (dma_keep),
        .i_dma_wr_data  (dma_data),
        .o_dma_wr_ready (dma_ready),
        .o_wr_finish    (finish),
        .m_axi          (axi.master),
        .o_wr_err       (wr_err),
        .o_busy         (busy),
        .o_state        (state)
    );

    function automatic logic [63:0] mk_data(input int s);
        return {32'hC0DE_0000 ^ 32'(s * 7), 32'(s)};
    endfunction

    function automatic logic [7:0] mk_keep(input int s);
        return (s % 5 == 4) ? 8'h0F : 8'hFF;
    endfunction

    // FWFT source: valid = not-empty & ready
    int src_seq = 0;
    assign dma_valid = src_avail & dma_ready;
    assign dma_data  = mk_data(src_seq);
    assign dma_keep  = mk_keep(src_seq);

    // configuration written only by the test process
    bit rand_w    = 1'b0;
    bit rand_src  = 1'b0;
    int err_burst = -1;

    // monitor / AXI slave / source state, written only by the monitor process
    int          cyc = 0, n_aw = 0, n_beats = 0, n_ack = 0, n_fin = 0;
    int          ack_cyc = 0, fin_cyc = 0;
    int          data_bad = 0, wlast_bad = 0, ready_bad = 0;
    int          exp_seq = 0, bib = 0;
    bit          b_pend = 1'b0, burst_open = 1'b0, s_hs = 1'b0;
    logic [31:0] aw_addr_q [0:255];
    logic [7:0]  aw_len_q  [0:255];

    always begin
        @(negedge clk);
        cyc++;
        if (rst || soft_rst) begin
            b_pend     = 1'b0;
            burst_open = 1'b0;
            bib        = 0;
            s_hs       = 1'b0;
            exp_seq    = src_seq;
        end else begin
            if (dma_ready && state != ST_W) ready_bad++;
            if (cmd_ack) begin n_ack++; ack_cyc = cyc; end
            if (finish)  begin n_fin++; fin_cyc = cyc; end
            s_hs = dma_valid;
            if (axi.awvalid && axi.awready) begin
                if (burst_open && bib != int'(aw_len_q[n_aw-1]) + 1) wlast_bad++;
                aw_addr_q[n_aw] = axi.awaddr;
                aw_len_q[n_aw]  = axi.awlen;
                n_aw++;
                bib        = 0;
                burst_open = 1'b1;
            end
            if (axi.wvalid && axi.wready) begin
                bib++;
                n_beats++;
                if (axi.wdata !== mk_data(exp_seq) || axi.wstrb !== mk_keep(exp_seq)) data_bad++;
                if (!burst_open || axi.wlast !== (bib == int'(aw_len_q[n_aw-1]) + 1)) wlast_bad++;
                exp_seq++;
                if (axi.wlast) b_pend = 1'b1;
            end
            if (axi.bvalid && axi.bready) b_pend = 1'b0;
        end
        @(posedge clk);
        #1;
        if (s_hs) src_seq++;
        if (rst || soft_rst) begin
            axi.awready = 1'b0;
            axi.wready  = 1'b0;
            axi.bvalid  = 1'b0;
            axi.bresp   = 2'b00;
            src_avail   = 1'b0;
        end else begin
            axi.awready = rand_w ? 1'($urandom_range(0, 1)) : 1'b1;
            axi.wready  = rand_w ? 1'($urandom_range(0, 1)) : 1'b1;
            src_avail   = rand_src ? ($urandom_range(0, 3) != 0) : 1'b1;
            axi.bvalid  = b_pend;
            axi.bresp   = (n_aw - 1 == err_burst) ? 2'b10 : 2'b00;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [15:0] len;
        bit          rw;
        bit          rs;
        int          exp_bursts;
        int          exp_beats;
        int          exp_first_len;
        int          exp_last_len;
        logic [31:0] exp_first_addr;
        logic [31:0] exp_last_addr;
        bit          exp_err;
    } vec_t;

    vec_t vecs [8];
    int   b_aw, b_beats, b_ack, b_fin;

    task automatic do_cmd(input logic [31:0] a, input logic [15:0] l, output bit done);
        bit got;
        b_aw    = n_aw;
        b_beats = n_beats;
        b_ack   = n_ack;
        b_fin   = n_fin;
        done    = 1'b0;
        @(posedge clk); #1;
        cmd_data = {a, l};
        cmd_req  = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (cmd_ack) got = 1'b1;
        end
        @(posedge clk); #1;
        cmd_req = 1'b0;
        if (!got) begin
            check("ack_timeout", 0, 1);
            return;
        end
        got = 1'b0;
        for (int n = 0; n < 20000 && !got; n++) begin
            @(negedge clk);
            if (finish) got = 1'b1;
        end
        if (!got) check("finish_timeout", 0, 1);
        repeat (2) @(negedge clk);
        #1;
        done = got;
    endtask

    task automatic do_vec(input string tag, input vec_t v);
        bit ok;
        int step_bad;
        rand_w   = v.rw;
        rand_src = v.rs;
        do_cmd(v.addr, v.len, ok);
        check({tag, "_acks"},   n_ack - b_ack, 1);
        check({tag, "_finish"}, n_fin - b_fin, 1);
        check({tag, "_bursts"}, n_aw - b_aw, v.exp_bursts);
        check({tag, "_beats"},  n_beats - b_beats, v.exp_beats);
        if (v.exp_bursts > 0) begin
            check({tag, "_first_awlen"}, aw_len_q[b_aw], v.exp_first_len);
            check({tag, "_last_awlen"},  aw_len_q[n_aw-1], v.exp_last_len);
            check({tag, "_first_addr"},  aw_addr_q[b_aw], v.exp_first_addr);
            check({tag, "_last_addr"},   aw_addr_q[n_aw-1], v.exp_last_addr);
            step_bad = 0;
            for (int i = b_aw + 1; i < n_aw; i++)
                if (aw_addr_q[i] != aw_addr_q[i-1] + 32'((int'(aw_len_q[i-1]) + 1) * 8)) step_bad++;
            check({tag, "_addr_step"}, step_bad, 0);
        end else begin
            check({tag, "_len0_latency"}, fin_cyc - ack_cyc, 2);
        end
        check({tag, "_data"},  data_bad, 0);
        check({tag, "_wlast"}, wlast_bad, 0);
        check({tag, "_ready"}, ready_bad, 0);
        check({tag, "_err"},   wr_err, v.exp_err);
        check({tag, "_busy"},  busy, 0);
        rand_w   = 1'b0;
        rand_src = 1'b0;
    endtask

    task automatic pulse_rst();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   ok;
        bit   got;
        vec_t v;
        rst      = 1'b1;
        soft_rst = 1'b0;
        cmd_req  = 1'b0;
        cmd_data = '0;

        //            addr          len     rw    rs    bur beats first last first_addr    last_addr     err
        vecs[0] = '{32'h1000_0000, 16'd888, 1'b0, 1'b0, 7, 111, 15, 14, 32'h1000_0000, 32'h1000_0300, 1'b0};
        vecs[1] = '{32'h0000_0FF8, 16'd64,  1'b0, 1'b0, 2, 8,   0,  6,  32'h0000_0FF8, 32'h0000_1000, 1'b0};
        vecs[2] = '{32'h2000_0000, 16'd882, 1'b1, 1'b1, 7, 111, 15, 14, 32'h2000_0000, 32'h2000_0300, 1'b0};
        vecs[3] = '{32'h0000_0F80, 16'd256, 1'b1, 1'b0, 2, 32,  15, 15, 32'h0000_0F80, 32'h0000_1000, 1'b0};
        vecs[4] = '{32'h0000_0FC0, 16'd200, 1'b0, 1'b1, 3, 25,  7,  0,  32'h0000_0FC0, 32'h0000_1080, 1'b0};
        vecs[5] = '{32'h0000_0040, 16'd8,   1'b1, 1'b1, 1, 1,   0,  0,  32'h0000_0040, 32'h0000_0040, 1'b0};
        vecs[6] = '{32'h3000_0000, 16'd0,   1'b0, 1'b0, 0, 0,   0,  0,  32'h0,         32'h0,         1'b0};
        vecs[7] = '{32'h0000_0104, 16'd16,  1'b0, 1'b0, 1, 2,   1,  1,  32'h0000_0100, 32'h0000_0100, 1'b1};

        // reset state
        repeat (3) @(negedge clk);
        check("rst_ack",     cmd_ack, 0);
        check("rst_ready",   dma_ready, 0);
        check("rst_finish",  finish, 0);
        check("rst_awvalid", axi.awvalid, 0);
        check("rst_wvalid",  axi.wvalid, 0);
        check("rst_bready",  axi.bready, 0);
        check("rst_err",     wr_err, 0);
        check("rst_busy",    busy, 0);
        check("rst_state",   state, ST_IDLE);
        @(posedge clk); #1;
        rst = 1'b0;

        // table-driven commands
        for (int i = 0; i < 8; i++) do_vec($sformatf("v%0d", i), vecs[i]);

        // soft reset clears the sticky error
        @(posedge clk); #1;
        soft_rst = 1'b1;
        @(posedge clk); #1;
        soft_rst = 1'b0;
        @(negedge clk);
        check("soft_rst_err",   wr_err, 0);
        check("soft_rst_state", state, ST_IDLE);

        // SLVERR on burst 2 of 3: sticky error, transfer still completes once
        err_burst = n_aw + 1;
        do_cmd(32'h4000_0000, 16'd384, ok);
        err_burst = -1;
        check("berr_bursts", n_aw - b_aw, 3);
        check("berr_finish", n_fin - b_fin, 1);
        check("berr_beats",  n_beats - b_beats, 48);
        check("berr_err",    wr_err, 1);
        do_cmd(32'h4000_1000, 16'd64, ok);
        check("berr_sticky", wr_err, 1);
        check("berr_finish2", n_fin - b_fin, 1);
        pulse_rst();

        // async reset during W beat 5 abandons the transfer
        b_fin = n_fin;
        b_beats = n_beats;
        @(posedge clk); #1;
        cmd_data = {32'h5000_0000, 16'd256};
        cmd_req  = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (cmd_ack) got = 1'b1;
        end
        @(posedge clk); #1;
        cmd_req = 1'b0;
        check("mid_rst_ack", got, 1);
        got = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk); #1;
            if (n_beats - b_beats >= 5) got = 1'b1;
        end
        check("mid_rst_reach_beat5", got, 1);
        check("mid_rst_in_w", state, ST_W);
        rst = 1'b1;
        #1;
        check("mid_rst_awvalid", axi.awvalid, 0);
        check("mid_rst_wvalid",  axi.wvalid, 0);
        check("mid_rst_ready",   dma_ready, 0);
        check("mid_rst_busy",    busy, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_no_finish", n_fin - b_fin, 0);
        v = '{32'h5000_0000, 16'd64, 1'b0, 1'b0, 1, 8, 7, 7, 32'h5000_0000, 32'h5000_0000, 1'b0};
        do_vec("post_rst", v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
